// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - value/strobe inputs and scanned display outputs of seg_scan_mux
interface seg_scan_mux_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] data_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   blank_in;
   logic                load;
   logic [DIGITS-1:0]   an;
   logic [6:0]          seg;
   logic                dp;
   logic                frame;

   modport master (
      output data_in, dp_in, blank_in, load,
      input  an, seg, dp, frame
   );

   modport slave (
      input  data_in, dp_in, blank_in, load,
      output an, seg, dp, frame
   );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - double-buffered time-multiplexed hex seven-segment driver
// Optional feature: SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_mux #(
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic          clk,
   input  logic          reset,
   seg_scan_mux_if.slave bus
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [DIV_W-1:0]    div_q, div_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] pend_nib_q, pend_nib_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic [4*DIGITS-1:0] act_nib_q, act_nib_d;
   logic [DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [DIGITS-1:0]   act_blank_q, act_blank_d;
   logic                boundary_q;
   logic                frame_q;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;

   logic                tc;
   logic                wrap;
   logic [DIGITS-1:0]   lz_blank;
   logic [DIGITS-1:0]   an_hot;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic [6:0]          seg_on;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Scan timing and buffer transfer; a load on the wrap cycle bypasses pending.
   always_comb begin
      tc   = (div_q == DIV_LAST);
      wrap = tc && (idx_q == IDX_LAST);

      div_d = tc ? '0 : div_q + DIV_W'(1);
      idx_d = idx_q;
      if (tc) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      pend_nib_d   = pend_nib_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      if (bus.load) begin
         pend_nib_d   = bus.data_in;
         pend_dp_d    = bus.dp_in;
         pend_blank_d = bus.blank_in;
      end

      act_nib_d   = act_nib_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      if (wrap) begin
         act_nib_d   = pend_nib_d;
         act_dp_d    = pend_dp_d;
         act_blank_d = pend_blank_d;
      end
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // A zero run from the top digit downward stays dark until a nonzero nibble or a dp.
   always_comb begin
      logic run;
      run      = 1'b1;
      lz_blank = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         run         = run & (act_nib_q[4*k +: 4] == 4'h0) & ~act_dp_q[k];
         lz_blank[k] = run & (k != 0);
      end
   end
`else
   always_comb begin
      lz_blank = '0;
   end
`endif

   always_comb begin
      an_hot    = '0;
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            an_hot[k] = 1'b1;
            cur_nib   = act_nib_q[4*k +: 4];
            cur_dp    = act_dp_q[k];
            cur_blank = act_blank_q[k] | lz_blank[k];
         end
      end

      // Blanked digits keep their anode on so every digit gets the same duty cycle.
      seg_on = cur_blank ? 7'h00 : hex7(cur_nib);
      an_d   = an_hot ^ {DIGITS{POL}};
      seg_d  = seg_on ^ {7{POL}};
      dp_d   = (cur_dp & ~cur_blank) ^ POL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q        <= '0;
         idx_q        <= '0;
         pend_nib_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         act_nib_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         boundary_q   <= 1'b0;
         frame_q      <= 1'b0;
         an_q         <= {DIGITS{POL}};
         seg_q        <= {7{POL}};
         dp_q         <= POL;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         pend_nib_q   <= pend_nib_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         act_nib_q    <= act_nib_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         // Delayed one stage so the pulse lines up with the new frame's first output.
         boundary_q   <= wrap;
         frame_q      <= boundary_q;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign bus.an    = an_q;
   assign bus.seg   = seg_q;
   assign bus.dp    = dp_q;
   assign bus.frame = frame_q;

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised time-multiplexed seven-segment display driver for the seven-segment project: holds DIGITS hex nibbles, scans one digit at a time at a programmable refresh rate, and drives the shared segment bus plus one anode enable per digit. Generalises the fixed 8-way digit mux with a configurable digit count and polarity, per-digit blanking and decimal points, and tear-free double-buffered updates. It sits between the value-producing logic and the board's anode and segment pins.

## Interface
- DIGITS, 8, number of digits scanned (2..16).
- REFRESH_DIV, 100000, clock cycles each digit stays lit (≥2).
- ACTIVE_LOW, 1, 1: `an`, `seg` and `dp` are active-low (common-anode board); 0: active-high.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  4*DIGITS  nibble k = data_in[4k+3:4k] is digit k; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point request per digit.
- blank_in  in  DIGITS  1 forces that digit dark.
- load  in  1  single-cycle strobe that captures data_in, dp_in and blank_in into the pending buffer.
- an  out  DIGITS  digit enables, one-hot active.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point of the lit digit.
- frame  out  1  one-cycle pulse when the pending buffer is copied to the active buffer.

## Operation
- Divider `div` counts 0..REFRESH_DIV-1. At terminal count, digit index `idx` advances (DIGITS-1 wraps to 0) and `div` returns to 0.
- Two buffers, each holding nibbles, dp bits and blank bits:
  - pending: written when `load`=1.
  - active: what is displayed.
- Frame boundary is the cycle where `idx` wraps to 0. At that cycle active takes pending and `frame` pulses.
- If `load` coincides with a boundary, active takes data_in, dp_in and blank_in directly, and pending takes them too.
- Multiple loads within one frame: the last one wins.
- Decoder is hex 0-F. Active-high codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- A blanked digit drives `seg` and `dp` off, but `an` stays on to keep brightness uniform.
- When ACTIVE_LOW=1, `an`, `seg` and `dp` are bitwise inverted.

## Timing
- Reset (synchronous, dominant over load):
  - `div`, `idx`, both buffers and `frame` are cleared to 0.
  - `an`, `seg` and `dp` are all inactive (all 1s when ACTIVE_LOW=1).
  - Reset asserted mid-scan abandons the frame and discards any pending load.
- Outputs are registered, one cycle behind `idx` and the active buffer.
  - First cycle after reset release: an[0] is active and shows digit 0 (value 0 → "0").
- Each digit is lit for exactly REFRESH_DIV cycles. A full frame is DIGITS*REFRESH_DIV cycles.
- `frame` is registered; it is high the cycle after the boundary edge, i.e. aligned with the first output cycle of the new frame.
- A load takes effect on the display no later than one frame plus one cycle after the strobe, and never part-way through a frame.
- `an` is never multi-hot, including across reset entry and exit.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined:
  - Digits from DIGITS-1 downward whose active nibble is 0 are treated as blanked until the first nonzero digit.
  - Digit 0 is never blank-suppressed.
  - A digit with dp set stops the suppression, so it and all lower digits display.
- Not defined: every digit shows its nibble; only blank_in darkens a digit.

## Test plan
- DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1; release reset → an=1110, seg=40 (digit "0"), and `an` steps 1101, 1011, 0111 every 4 cycles, then wraps to 1110.
- load data_in=16'h12AF mid-frame → display unchanged until the boundary; `frame` pulses; the next frame shows seg=0E (F), 08 (A), 24 (2), 79 (1) on digits 0..3.
- load asserted on the exact boundary cycle with 16'h8888 → that same new frame shows seg=00 on all digits; `frame`=1 once.
- blank_in=4'b0100, dp_in=4'b0001 → digit 2 shows seg=7F, dp=1 with an=1011; digit 0 shows dp=0.
- reset pulse during digit 2 with a load pending → next cycle an=1111, seg=7F; after release the display shows 0000, not the pending value.
- With SEG_LEADING_ZERO_BLANK_EN, load 16'h0050 → digits 3 and 2 blank (seg=7F), digits 1 and 0 show "5" (12) and "0" (40). Without the macro, all four digits are lit.
